// File: rtl/ijtc_repair_writer.sv
// Write side of the indirect jump target cache: owns the GHR, repairs it from
// resolved-branch reports and drains queued table writes after a full-table invalidate.
module ijtc_repair_writer #(
    parameter int GHR_LEN    = 8,
    parameter int IDX_LEN    = 8,
    parameter int TAG_LEN    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rep_valid_i,
    output logic               rep_ready_o,
    input  logic [GHR_LEN-1:0] rep_checkpoint_i,
    input  logic [31:0]        rep_vaddr_i,
    input  logic               rep_take_i,
    input  logic               rep_indirect_i,
    input  logic [31:0]        rep_dest_i,
    input  logic               spec_valid_i,
    input  logic               spec_take_i,
    output logic [GHR_LEN-1:0] ghr_o,
    output logic               wr_en_o,
    input  logic               wr_ready_i,
    output logic [IDX_LEN-1:0] wr_idx_o,
    output logic [TAG_LEN-1:0] wr_tag_o,
    output logic [31:0]        wr_dest_o,
    output logic               wr_valid_o,
    output logic               busy_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [IDX_LEN-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {INIT, IDLE, WRITE} state_t;

    state_t             state, state_next;
    logic [IDX_LEN-1:0] init_cnt;
    logic [GHR_LEN-1:0] ghr;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    logic [IDX_LEN-1:0] fifo_idx  [FIFO_DEPTH];
    logic [TAG_LEN-1:0] fifo_tag  [FIFO_DEPTH];
    logic [31:0]        fifo_dest [FIFO_DEPTH];

    logic accept, push, pop;
    logic [IDX_LEN-1:0] new_idx;
    logic [TAG_LEN-1:0] new_tag;
    logic               unused_vaddr_bits;

    assign rep_ready_o = !rst && (count < DEPTH_C);
    assign accept      = rep_valid_i && rep_ready_o;
    assign push        = accept && rep_indirect_i && rep_take_i;
    assign pop         = !rst && (state == WRITE) && wr_ready_i;

    // Index uses the pre-branch history so it matches what the lookup side hashed.
    assign new_idx = rep_vaddr_i[IDX_LEN+1:2] ^ IDX_LEN'(rep_checkpoint_i);
    assign new_tag = rep_vaddr_i[IDX_LEN+TAG_LEN+1:IDX_LEN+2];
    assign unused_vaddr_bits = ^{rep_vaddr_i[1:0], rep_vaddr_i[31:IDX_LEN+TAG_LEN+2]};

    assign ghr_o = ghr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (accept) begin
            ghr <= {rep_checkpoint_i[GHR_LEN-2:0], rep_take_i};
        end else if (spec_valid_i) begin
            ghr <= {ghr[GHR_LEN-2:0], spec_take_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr]  <= new_idx;
            fifo_tag[wr_ptr]  <= new_tag;
            fifo_dest[wr_ptr] <= rep_dest_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == INIT && wr_ready_i) init_cnt <= init_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:  if (wr_ready_i && init_cnt == LAST_IDX) state_next = IDLE;
            IDLE:  if (count != '0) state_next = WRITE;
            WRITE: begin
                // A push landing in the same cycle as the last pop keeps us writing.
                if (wr_ready_i && count == CNT_W'(1) && !push) state_next = IDLE;
            end
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        wr_en_o    = 1'b0;
        wr_idx_o   = '0;
        wr_tag_o   = '0;
        wr_dest_o  = '0;
        wr_valid_o = 1'b0;
        busy_o     = rst || (state == INIT) || (count != '0);
        if (!rst) begin
            case (state)
                INIT: begin
                    wr_en_o  = 1'b1;
                    wr_idx_o = init_cnt;
                end
                WRITE: begin
                    wr_en_o    = 1'b1;
                    wr_idx_o   = fifo_idx[rd_ptr];
                    wr_tag_o   = fifo_tag[rd_ptr];
                    wr_dest_o  = fifo_dest[rd_ptr];
                    wr_valid_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ijtc_repair_writer.sv
// Directed bench for ijtc_repair_writer: invalidate sweep, repair/enqueue,
// back-pressure, GHR priority, non-enqueuing reports and reset during WRITE.
module tb_ijtc_repair_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rep_valid_i, rep_ready_o;
    logic [7:0]  rep_checkpoint_i;
    logic [31:0] rep_vaddr_i;
    logic        rep_take_i, rep_indirect_i;
    logic [31:0] rep_dest_i;
    logic        spec_valid_i, spec_take_i;
    logic [7:0]  ghr_o;
    logic        wr_en_o, wr_ready_i;
    logic [7:0]  wr_idx_o, wr_tag_o;
    logic [31:0] wr_dest_o;
    logic        wr_valid_o, busy_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] vaddrs [5];
    logic [31:0] dests  [5];

    always #5 clk = ~clk;

    ijtc_repair_writer dut (
        .clk              (clk),
        .rst              (rst),
        .rep_valid_i      (rep_valid_i),
        .rep_ready_o      (rep_ready_o),
        .rep_checkpoint_i (rep_checkpoint_i),
        .rep_vaddr_i      (rep_vaddr_i),
        .rep_take_i       (rep_take_i),
        .rep_indirect_i   (rep_indirect_i),
        .rep_dest_i       (rep_dest_i),
        .spec_valid_i     (spec_valid_i),
        .spec_take_i      (spec_take_i),
        .ghr_o            (ghr_o),
        .wr_en_o          (wr_en_o),
        .wr_ready_i       (wr_ready_i),
        .wr_idx_o         (wr_idx_o),
        .wr_tag_o         (wr_tag_o),
        .wr_dest_o        (wr_dest_o),
        .wr_valid_o       (wr_valid_o),
        .busy_o           (busy_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] cp, input logic [31:0] vaddr,
                                 input logic take, input logic indirect, input logic [31:0] dest);
        rep_valid_i      = valid;
        rep_checkpoint_i = cp;
        rep_vaddr_i      = vaddr;
        rep_take_i       = take;
        rep_indirect_i   = indirect;
        rep_dest_i       = dest;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] modelIdx(input logic [31:0] vaddr, input logic [7:0] cp);
        return vaddr[9:2] ^ cp;
    endfunction

    function automatic logic [7:0] modelTag(input logic [31:0] vaddr);
        return vaddr[17:10];
    endfunction

    initial begin
        rst = 1'b1;
        wr_ready_i = 1'b1;
        spec_valid_i = 1'b0;
        spec_take_i = 1'b0;
        applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 32'h0);

        tick();
        tick();
        checkOutput("rst_wr_en", 32'(wr_en_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd1);
        checkOutput("rst_ready", 32'(rep_ready_o), 32'd0);
        checkOutput("rst_ghr", 32'(ghr_o), 32'd0);
        checkOutput("rst_idx", 32'(wr_idx_o), 32'd0);

        // Invalidate sweep: exactly 256 write cycles with ready held high.
        rst = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) begin
            checkOutput("init_wr_en", 32'(wr_en_o), 32'd1);
            checkOutput("init_idx", 32'(wr_idx_o), 32'(i));
            checkOutput("init_valid", 32'(wr_valid_o), 32'd0);
            tick();
        end
        checkOutput("idle_wr_en", 32'(wr_en_o), 32'd0);
        checkOutput("idle_busy", 32'(busy_o), 32'd0);
        checkOutput("idle_ghr", 32'(ghr_o), 32'd0);
        checkOutput("idle_ready", 32'(rep_ready_o), 32'd1);

        // Single indirect-taken report, two-cycle latency to the table write.
        applyStimulus(1'b1, 8'h5A, 32'h0000_1234, 1'b1, 1'b1, 32'h8000_0040);
        checkOutput("t2_ready", 32'(rep_ready_o), 32'd1);
        tick();
        applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t2_ghr", 32'(ghr_o), 32'h0000_00B5);
        checkOutput("t2_early_wr_en", 32'(wr_en_o), 32'd0);
        checkOutput("t2_busy", 32'(busy_o), 32'd1);
        tick();
        checkOutput("t2_wr_en", 32'(wr_en_o), 32'd1);
        checkOutput("t2_idx", 32'(wr_idx_o), 32'h0000_00D7);
        checkOutput("t2_tag", 32'(wr_tag_o), 32'(modelTag(32'h0000_1234)));
        checkOutput("t2_dest", wr_dest_o, 32'h8000_0040);
        checkOutput("t2_valid", 32'(wr_valid_o), 32'd1);
        tick();
        checkOutput("t2_done_wr_en", 32'(wr_en_o), 32'd0);
        checkOutput("t2_done_busy", 32'(busy_o), 32'd0);

        // Back-pressure: five reports against a stalled table, fifth refused.
        wr_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vaddrs[k] = 32'h0001_0000 + 32'(k) * 32'h0000_0C14;
            dests[k]  = 32'hA000_0000 + 32'(k) * 32'h10;
            applyStimulus(1'b1, 8'h30 + 8'(k), vaddrs[k], 1'b1, 1'b1, dests[k]);
            checkOutput("t3_ready", 32'(rep_ready_o), (k < 4) ? 32'd1 : 32'd0);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t3_ghr", 32'(ghr_o), 32'h0000_0067);
        for (int s = 0; s < 2; s++) begin
            checkOutput("t3_hold_en", 32'(wr_en_o), 32'd1);
            checkOutput("t3_hold_dest", wr_dest_o, dests[0]);
            checkOutput("t3_hold_idx", 32'(wr_idx_o), 32'(modelIdx(vaddrs[0], 8'h30)));
            tick();
        end
        wr_ready_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            checkOutput("t3_drain_en", 32'(wr_en_o), 32'd1);
            checkOutput("t3_drain_dest", wr_dest_o, dests[j]);
            checkOutput("t3_drain_idx", 32'(wr_idx_o), 32'(modelIdx(vaddrs[j], 8'h30 + 8'(j))));
            checkOutput("t3_drain_tag", 32'(wr_tag_o), 32'(modelTag(vaddrs[j])));
            tick();
            checkOutput("t3_ready_back", 32'(rep_ready_o), 32'd1);
        end
        checkOutput("t3_end_en", 32'(wr_en_o), 32'd0);
        checkOutput("t3_end_busy", 32'(busy_o), 32'd0);

        // Repair beats a simultaneous speculative update.
        spec_valid_i = 1'b1;
        spec_take_i  = 1'b1;
        applyStimulus(1'b1, 8'h01, 32'h0000_2000, 1'b0, 1'b1, 32'h0);
        tick();
        applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t4_repair_wins", 32'(ghr_o), 32'h0000_0002);
        tick();
        spec_valid_i = 1'b0;
        checkOutput("t4_spec", 32'(ghr_o), 32'h0000_0005);
        checkOutput("t4_wr_en", 32'(wr_en_o), 32'd0);

        // Non-indirect and not-taken reports only repair the GHR.
        applyStimulus(1'b1, 8'h33, 32'h0000_3000, 1'b1, 1'b0, 32'h1234_5678);
        tick();
        applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t5a_ghr", 32'(ghr_o), 32'h0000_0067);
        checkOutput("t5a_busy", 32'(busy_o), 32'd0);
        tick();
        checkOutput("t5a_wr_en", 32'(wr_en_o), 32'd0);
        applyStimulus(1'b1, 8'h80, 32'h0000_4000, 1'b0, 1'b1, 32'h1234_5678);
        tick();
        applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t5b_ghr", 32'(ghr_o), 32'h0000_0000);
        checkOutput("t5b_busy", 32'(busy_o), 32'd0);
        tick();
        checkOutput("t5b_wr_en", 32'(wr_en_o), 32'd0);

        // Reset in WRITE with three entries queued drops everything.
        wr_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 8'h10, 32'h0000_5000 + 32'(k) * 4, 1'b1, 1'b1, 32'hB000_0000 + 32'(k));
            tick();
        end
        applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t6_write_en", 32'(wr_en_o), 32'd1);
        checkOutput("t6_full_ready", 32'(rep_ready_o), 32'd1);
        rst = 1'b1;
        tick();
        checkOutput("t6_rst_en", 32'(wr_en_o), 32'd0);
        checkOutput("t6_rst_busy", 32'(busy_o), 32'd1);
        checkOutput("t6_rst_ghr", 32'(ghr_o), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("t6_init_en", 32'(wr_en_o), 32'd1);
        checkOutput("t6_init_idx", 32'(wr_idx_o), 32'd0);
        checkOutput("t6_init_valid", 32'(wr_valid_o), 32'd0);
        checkOutput("t6_ready", 32'(rep_ready_o), 32'd1);
        wr_ready_i = 1'b1;
        tick();
        checkOutput("t6_init_idx1", 32'(wr_idx_o), 32'd1);
        for (int i = 1; i < 256; i++) tick();
        checkOutput("t6_end_en", 32'(wr_en_o), 32'd0);
        checkOutput("t6_end_busy", 32'(busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
